// File: rtl/id_pipe.sv
// id_pipe: registered instruction-decode stage.
// Decodes one fetched instruction per cycle into a control/operand bundle held
// in an output register toward execute. Detects load-use hazards against the
// load currently in execute and inserts bubbles, honours flush, and counts
// hazard stall cycles in a saturating counter.
//
// Handshake: a transfer happens on a cycle where valid and ready are both high
// at the rising edge; the producer holds its payload stable while valid is high
// and ready is low, and ready never depends on the producer's payload except
// through the load-use hazard check.
module id_pipe #(
  parameter int INS_W    = 16,
  parameter int RIDX_W   = 3,
  parameter int IMM_W    = 8,
  parameter int STALL_CW = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INS_W-1:0]    in_ins,
  input  logic [INS_W-1:0]    in_pc,
  input  logic                flush,
  input  logic                ex_load_valid,
  input  logic [RIDX_W-1:0]   ex_load_rd,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [INS_W-1:0]    out_pc,
  output logic [3:0]          alu_signal,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_we,
  output logic [RIDX_W-1:0]   rd,
  output logic [RIDX_W-1:0]   rs1,
  output logic [RIDX_W-1:0]   rs2,
  output logic [IMM_W-1:0]    imm,
  output logic [INS_W-1:0]    branch_offset,
  output logic                bra,
  output logic                jmp,
  output logic                ret,
  output logic                apc,
  output logic                illegal,
  output logic [STALL_CW-1:0] stall_cnt
);

  typedef struct packed {
    logic [INS_W-1:0]  pc;
    logic [3:0]        alu;
    logic              mem_read;
    logic              mem_write;
    logic              reg_we;
    logic [RIDX_W-1:0] rd;
    logic [RIDX_W-1:0] rs1;
    logic [RIDX_W-1:0] rs2;
    logic [IMM_W-1:0]  imm;
    logic [INS_W-1:0]  offset;
    logic              bra;
    logic              jmp;
    logic              ret;
    logic              apc;
    logic              illegal;
  } bundle_t;

  // Raw instruction fields: opcode on top, then rd, rs1, rs2 packed below it.
  logic [3:0]        f_op;
  logic [RIDX_W-1:0] f_rd;
  logic [RIDX_W-1:0] f_rs1;
  logic [RIDX_W-1:0] f_rs2;

  assign f_op  = in_ins[INS_W-1 -: 4];
  assign f_rd  = in_ins[INS_W-5 -: RIDX_W];
  assign f_rs1 = in_ins[INS_W-5-RIDX_W -: RIDX_W];
  assign f_rs2 = in_ins[INS_W-5-2*RIDX_W -: RIDX_W];

  bundle_t           bundle_d, bundle_q;
  logic              out_valid_d, out_valid_q;
  logic [STALL_CW-1:0] stall_d, stall_q;
  logic              uses_rs1, uses_rs2, uses_rd;
  logic              haz, accept;

  // Decode the incoming instruction and note which source registers it reads.
  // APC reads rs1 as its operand, so it takes part in load-use detection.
  always_comb begin
    bundle_d        = '0;
    bundle_d.pc     = in_pc;
    bundle_d.rd     = f_rd;
    bundle_d.rs1    = f_rs1;
    bundle_d.rs2    = f_rs2;
    bundle_d.imm    = in_ins[IMM_W-1:0];
    uses_rs1        = 1'b0;
    uses_rs2        = 1'b0;
    uses_rd         = 1'b0;
    case (f_op)
      4'h0: begin
        bundle_d.alu    = {1'b0, in_ins[2:0]};
        bundle_d.reg_we = 1'b1;
        uses_rs1        = 1'b1;
        uses_rs2        = 1'b1;
      end
      4'h1: begin
        bundle_d.reg_we = 1'b1;
        uses_rs1        = 1'b1;
      end
      4'h2: begin
        bundle_d.mem_read = 1'b1;
        bundle_d.reg_we   = 1'b1;
        uses_rs1          = 1'b1;
      end
      4'h3: begin
        bundle_d.mem_write = 1'b1;
        bundle_d.rs2       = f_rd;
        uses_rs1           = 1'b1;
        uses_rd            = 1'b1;
      end
      4'h4: begin
        bundle_d.bra    = 1'b1;
        bundle_d.offset = {{(INS_W-9){in_ins[8]}}, in_ins[8:0]};
        uses_rd         = 1'b1;
      end
      4'h5: begin
        bundle_d.jmp    = 1'b1;
        bundle_d.offset = {{4{in_ins[INS_W-5]}}, in_ins[INS_W-5:0]};
      end
      4'h6: bundle_d.ret = 1'b1;
      4'h7: begin
        bundle_d.apc    = 1'b1;
        bundle_d.reg_we = 1'b1;
        uses_rs1        = 1'b1;
      end
      default: bundle_d.illegal = 1'b1;
    endcase
  end

  // Hazard, handshake and next-state selection for the output register and counter.
  always_comb begin
    haz = in_valid & ex_load_valid &
          ((uses_rs1 & (ex_load_rd == f_rs1)) |
           (uses_rs2 & (ex_load_rd == f_rs2)) |
           (uses_rd  & (ex_load_rd == f_rd)));
    in_ready = !rst & (!out_valid_q | out_ready) & !haz & !flush;
    accept   = in_valid & in_ready;

    out_valid_d = out_valid_q;
    if (flush)          out_valid_d = 1'b0;
    else if (accept)    out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;

    stall_d = stall_q;
    if (haz && !flush && (stall_q != {STALL_CW{1'b1}})) stall_d = stall_q + 1'b1;
  end

  // Output register, valid flag and stall counter; bundle changes only on a transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
      stall_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      stall_q     <= stall_d;
      if (accept) bundle_q <= bundle_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_pc        = bundle_q.pc;
  assign alu_signal    = bundle_q.alu;
  assign mem_read      = bundle_q.mem_read;
  assign mem_write     = bundle_q.mem_write;
  assign reg_we        = bundle_q.reg_we;
  assign rd            = bundle_q.rd;
  assign rs1           = bundle_q.rs1;
  assign rs2           = bundle_q.rs2;
  assign imm           = bundle_q.imm;
  assign branch_offset = bundle_q.offset;
  assign bra           = bundle_q.bra;
  assign jmp           = bundle_q.jmp;
  assign ret           = bundle_q.ret;
  assign apc           = bundle_q.apc;
  assign illegal       = bundle_q.illegal;
  assign stall_cnt     = stall_q;

endmodule
